// File: rtl/uart_rx_frame_decoder.sv
// UART receive frame decoder: 2-flop synchronizer, mid-bit sampling FSM, parity/stop checks.
// Each decoded byte is presented with a one-cycle rx_valid; there is no backpressure.
module uart_rx_frame_decoder #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_EN    = 1'b1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, WAIT_HIGH
  } state_t;

  state_t           state_q;
  logic             rxd_meta_q, rxd_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             par_err_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q, parity_err_q, frame_err_q, busy_q;
  logic             bit_done, half_done;

  assign bit_done  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign half_done = (cnt_q == CNT_W'(HALF - 1));

  // Synchronizer resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxd_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (half_done) begin
            cnt_q <= '0;
            if (rxd_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_q     <= '0;
            shift_q   <= {rxd_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) state_q <= PARITY_EN ? PARITY : STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        PARITY: begin
          if (bit_done) begin
            cnt_q     <= '0;
            par_err_q <= (^shift_q) ^ rxd_s_q ^ PARITY_ODD;
            state_q   <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          // Leaving STOP at the mid-sample lets a start edge half a bit later be caught.
          if (bit_done) begin
            cnt_q        <= '0;
            rx_data_q    <= shift_q;
            parity_err_q <= PARITY_EN ? par_err_q : 1'b0;
            frame_err_q  <= ~rxd_s_q;
            rx_valid_q   <= 1'b1;
            if (rxd_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (rxd_s_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_decoder.sv
// Bench for uart_rx_frame_decoder: even, odd and no-parity instances, directed table plus random frames.
module tb_uart_rx_frame_decoder;

  localparam int CPB = 16;

  logic clk = 1'b0;
  logic reset_n;
  logic rxd, rxd_np;

  logic [7:0] e_data, o_data, n_data;
  logic e_vld, o_vld, n_vld;
  logic e_pe, o_pe, n_pe;
  logic e_fe, o_fe, n_fe;
  logic e_busy, o_busy, n_busy;

  always #5 clk = ~clk;

  uart_rx_frame_decoder #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rx_data(e_data), .rx_valid(e_vld),
    .parity_err(e_pe), .frame_err(e_fe), .busy(e_busy));

  uart_rx_frame_decoder #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rx_data(o_data), .rx_valid(o_vld),
    .parity_err(o_pe), .frame_err(o_fe), .busy(o_busy));

  uart_rx_frame_decoder #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_np (
    .clk(clk), .reset_n(reset_n), .rxd(rxd_np), .rx_data(n_data), .rx_valid(n_vld),
    .parity_err(n_pe), .frame_err(n_fe), .busy(n_busy));

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rx_t;

  rx_t q_e[$], q_o[$], q_n[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (e_vld) q_e.push_back('{e_data, e_pe, e_fe, cyc});
    if (o_vld) q_o.push_back('{o_data, o_pe, o_fe, cyc});
    if (n_vld) q_n.push_back('{n_data, n_pe, n_fe, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic check_rx(input string nm, input int inst, input logic [7:0] d,
                          input logic pe, input logic fe, output int c);
    rx_t r;
    bit  got;
    got = 1'b0;
    c   = 0;
    case (inst)
      0: if (q_e.size() > 0) begin r = q_e.pop_front(); got = 1'b1; end
      1: if (q_o.size() > 0) begin r = q_o.pop_front(); got = 1'b1; end
      default: if (q_n.size() > 0) begin r = q_n.pop_front(); got = 1'b1; end
    endcase
    if (!got) begin
      chk({nm, " rx_valid count"}, 32'd0, 32'd1);
    end else begin
      chk({nm, " data"}, {24'd0, r.d}, {24'd0, d});
      chk({nm, " parity_err"}, {31'd0, r.pe}, {31'd0, pe});
      chk({nm, " frame_err"}, {31'd0, r.fe}, {31'd0, fe});
      c = r.cyc;
    end
  endtask

  // Drive n line bits LSB first, each held for one bit period.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit np_line);
    for (int i = 0; i < n; i++) begin
      if (np_line) rxd_np = bits[i];
      else rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    send_bits({stp, par, d, 1'b0}, 11, 1'b0);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Reference: parity error when the total count of ones in data+parity is not the required parity.
  function automatic logic perr_model(input logic [7:0] d, input logic par, input logic odd);
    int ones;
    ones = $countones(d) + int'(par);
    return odd ? ((ones % 2) == 0) : ((ones % 2) != 0);
  endfunction

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic [7:0] exp_d;
    logic       exp_pe_even;
    logic       exp_pe_odd;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int c0, c1, c2;
    int sz_e, sz_o;
    bit saw_busy, dropped;
    logic [7:0] rd;
    logic rp, rs;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

    reset_n = 1'b0;
    rxd     = 1'b1;
    rxd_np  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset rx_data", {24'd0, e_data}, 32'd0);
    chk("reset rx_valid", {31'd0, e_vld}, 32'd0);
    chk("reset parity_err", {31'd0, e_pe}, 32'd0);
    chk("reset frame_err", {31'd0, e_fe}, 32'd0);
    chk("reset busy", {31'd0, e_busy}, 32'd0);
    reset_n = 1'b1;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stp);
      idle(CPB);
      check_rx($sformatf("vec%0d even", i), 0, vecs[i].exp_d, vecs[i].exp_pe_even, vecs[i].exp_fe, c0);
      check_rx($sformatf("vec%0d odd", i), 1, vecs[i].exp_d, vecs[i].exp_pe_odd, vecs[i].exp_fe, c0);
      chk($sformatf("vec%0d busy idle", i), {31'd0, e_busy}, 32'd0);
    end

    // Stop bit low followed by a held-low line: busy must persist until the line recovers.
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_rx("break 3C", 0, 8'h3C, 1'b0, 1'b1, c0);
    chk("break busy held", {31'd0, e_busy}, 32'd1);
    idle(6);
    chk("break busy released", {31'd0, e_busy}, 32'd0);
    send_frame(8'h55, 1'b0, 1'b1);
    idle(CPB);
    check_rx("after break 55", 0, 8'h55, 1'b0, 1'b0, c0);
    void'(q_o.size());
    q_o.delete();

    sz_e = q_e.size();
    sz_o = q_o.size();
    rxd = 1'b0;
    saw_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (e_busy) saw_busy = 1'b1;
    end
    rxd = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (e_busy) saw_busy = 1'b1;
      else if (saw_busy) dropped = 1'b1;
    end
    chk("glitch busy rose", {31'd0, saw_busy}, 32'd1);
    chk("glitch busy dropped", {31'd0, dropped}, 32'd1);
    idle(40);
    chk("glitch no rx_valid even", q_e.size(), sz_e);
    chk("glitch no rx_valid odd", q_o.size(), sz_o);

    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b1);
    idle(CPB);
    check_rx("b2b 00", 0, 8'h00, 1'b0, 1'b0, c0);
    check_rx("b2b FF", 0, 8'hFF, 1'b0, 1'b0, c1);
    check_rx("b2b 81", 0, 8'h81, 1'b0, 1'b0, c2);
    chk("b2b spacing 1", c1 - c0, 32'd176);
    chk("b2b spacing 2", c2 - c1, 32'd176);
    check_rx("b2b odd 00", 1, 8'h00, 1'b1, 1'b0, c0);
    check_rx("b2b odd FF", 1, 8'hFF, 1'b1, 1'b0, c0);
    check_rx("b2b odd 81", 1, 8'h81, 1'b1, 1'b0, c0);

    // Reset asserted half way through data bit 4.
    send_bits({1'b1, 1'b0, 8'h7E, 1'b0}, 5, 1'b0);
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midreset rx_data", {24'd0, e_data}, 32'd0);
    chk("midreset rx_valid", {31'd0, e_vld}, 32'd0);
    chk("midreset busy", {31'd0, e_busy}, 32'd0);
    chk("midreset flags", {30'd0, e_pe, e_fe}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2 * CPB);
    send_frame(8'h7E, 1'b0, 1'b1);
    idle(CPB);
    check_rx("post reset 7E", 0, 8'h7E, 1'b0, 1'b0, c0);
    chk("post reset single pulse", q_e.size(), 32'd0);
    q_o.delete();

    for (int i = 0; i < 20; i++) begin
      rd = 8'($urandom_range(0, 255));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rd, rp, rs);
      idle(CPB);
      check_rx($sformatf("rand%0d even", i), 0, rd, perr_model(rd, rp, 1'b0), ~rs, c0);
      check_rx($sformatf("rand%0d odd", i), 1, rd, perr_model(rd, rp, 1'b1), ~rs, c0);
    end

    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_bits({1'b1, rs, rd, 1'b0}, 11, 1'b1);
      check_rx($sformatf("nopar%0d", i), 2, rd, 1'b0, ~rs, c0);
    end

    idle(CPB);
    chk("final even queue empty", q_e.size(), 32'd0);
    chk("final odd queue empty", q_o.size(), 32'd0);
    chk("final nopar queue empty", q_n.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
